// File: rtl/sat_add_arbiter_if.sv
// sat_add_arbiter_if: request, result and status bundle for the shared
// saturating adder. The master side drives requests and downstream ready,
// and the slave side (the arbiter) drives grants, results and the counter.
interface sat_add_arbiter_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_sum;
  logic             res_id;
  logic             res_sat;
  logic [CNT_W-1:0] sat_count;
  logic             sat_clear;

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, res_ready, sat_clear,
    input  req_ready, res_valid, res_sum, res_id, res_sat, sat_count
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, res_ready, sat_clear,
    output req_ready, res_valid, res_sum, res_id, res_sat, sat_count
  );
endinterface

// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: two requesters share one signed saturating adder.
// Round-robin grant, operand register (stage 1), result register (stage 2),
// and a sticky-at-max counter of delivered clipped results.
module sat_add_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sat_add_arbiter_if.slave    bus
);

  logic             ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_id_q, s1_id_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_sum_q, res_sum_d;
  logic             res_id_q, res_id_d;
  logic             res_sat_q, res_sat_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic             s1_adv;
  logic             s1_can_load;
  logic             cand;
  logic [1:0]       ready;
  logic             accept;
  logic [W:0]       sum_ext;
  logic             ovf;
  logic [W-1:0]     sum_sat;

  // Stage advance and candidate selection; the pointer only matters when both ask.
  always_comb begin
    s1_adv      = s1_valid_q & (~res_valid_q | bus.res_ready);
    s1_can_load = ~s1_valid_q | s1_adv;
    if (&bus.req_valid) cand = ptr_q;
    else                cand = bus.req_valid[1];
  end

  // One grant bit per requester; only the candidate can be set, so at most one is high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready[gi] = rst & bus.req_valid[gi] & (cand == 1'(gi)) & s1_can_load;
  end

  assign accept = |(bus.req_valid & ready);

  // Saturating add on the stage-1 operands. Overflow shows up as the two top
  // bits of the sign-extended sum disagreeing, which happens exactly when the
  // operands share a sign that the truncated sum does not.
  always_comb begin
    sum_ext = {s1_a_q[W-1], s1_a_q} + {s1_b_q[W-1], s1_b_q};
    ovf     = sum_ext[W] ^ sum_ext[W-1];
    if (!ovf)            sum_sat = sum_ext[W-1:0];
    else if (sum_ext[W]) sum_sat = {1'b1, {(W-1){1'b0}}};
    else                 sum_sat = {1'b0, {(W-1){1'b1}}};
  end

  // Next-state for pointer, both pipeline stages and the event counter.
  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_sat_d   = res_sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (accept) begin
      ptr_d      = ~cand;
      s1_valid_d = 1'b1;
      s1_id_d    = cand;
      s1_a_d     = cand ? bus.req1_a : bus.req0_a;
      s1_b_d     = cand ? bus.req1_b : bus.req0_b;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Result fields change only on a load, so they stay put under backpressure.
    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum_sat;
      res_id_d    = s1_id_q;
      res_sat_d   = ovf;
    end else if (res_valid_q & bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    // Clear takes priority over a coincident clipped delivery.
    if (bus.sat_clear) begin
      sat_cnt_d = '0;
    end else if (res_valid_q & bus.res_ready & res_sat_q & ~(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops everything in flight and favours requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= 1'b0;
      res_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_sat_q   <= res_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.sat_count = sat_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// tb_sat_add_arbiter: scoreboard bench. Accepted requests push their expected
// result (computed with plain integer arithmetic) into a queue; a separate
// monitor pops and compares on every output handshake.
module tb_sat_add_arbiter;
  localparam int W       = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         id;
    logic         sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sat_add_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();
  sat_add_arbiter #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ref_ptr = 0;
  int   ref_cnt = 0;
  logic [1:0] rv = 2'b00;
  logic [1:0] acc = 2'b00;
  int   ra[2];
  int   rb[2];
  int   acc_total = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic prev_hold = 1'b0;
  logic [W-1:0] prev_sum;
  logic prev_id, prev_sat;
  logic [W-1:0] last_sum;
  logic last_id, last_sat;
  int   got_ids[$];
  int   got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, req, $time);
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  // Reference: exact integer sum clipped to the W-bit signed range.
  function automatic exp_t ref_add(input int a, input int b, input int id);
    exp_t e;
    int s, hi, lo;
    s  = a + b;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    e.id  = (id != 0);
    e.sat = 1'b0;
    if (s > hi) begin s = hi; e.sat = 1'b1; end
    else if (s < lo) begin s = lo; e.sat = 1'b1; end
    e.sum = W'(s);
    return e;
  endfunction

  // Expected grant from the request pattern, the round-robin pointer and how
  // many results are still owed (the pipeline holds at most two).
  task automatic model_step();
    logic [1:0] want;
    int c;
    #1;
    want = 2'b00;
    if (bus.req_valid != 2'b00 && (exp_q.size() < 2 || bus.res_ready)) begin
      if (bus.req_valid == 2'b11) c = ref_ptr;
      else c = bus.req_valid[1] ? 1 : 0;
      want[c] = 1'b1;
    end
    check("req_ready", bus.req_ready, want);
    acc = bus.req_valid & bus.req_ready;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        exp_q.push_back(ref_add(ra[i], rb[i], i));
        ref_ptr = 1 - i;
        acc_total++;
      end
    end
  endtask

  task automatic drive(input logic [1:0] v, input int a0, input int b0,
                       input int a1, input int b1, input logic rr, input logic clr);
    @(negedge clk);
    rv = v; ra[0] = a0; rb[0] = b0; ra[1] = a1; rb[1] = b1;
    bus.req_valid = v;
    bus.req0_a = W'(a0); bus.req0_b = W'(b0);
    bus.req1_a = W'(a1); bus.req1_b = W'(b1);
    bus.res_ready = rr;
    bus.sat_clear = clr;
    model_step();
  endtask

  // Random cycle: an unaccepted request keeps its operands unless it is dropped.
  task automatic rand_cycle(input int pv, input int pr, input int pclr, input int pdrop);
    logic [1:0] v;
    int a[2];
    int b[2];
    for (int i = 0; i < 2; i++) begin
      a[i] = ra[i]; b[i] = rb[i]; v[i] = rv[i];
      if (!(rv[i] && !acc[i] && int'($urandom_range(0, 99)) >= pdrop)) begin
        v[i] = (int'($urandom_range(0, 99)) < pv);
        a[i] = rnd();
        b[i] = rnd();
      end
    end
    drive(v, a[0], b[0], a[1], b[1], int'($urandom_range(0, 99)) < pr,
          int'($urandom_range(0, 99)) < pclr);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && k < 20) begin
      drive(2'b00, ra[0], rb[0], ra[1], rb[1], 1'b1, 1'b0);
      k++;
    end
    #2;
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: counter model, hold-stability under backpressure, result scoreboard.
  initial begin
    exp_t e;
    logic inc;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("sat_count", bus.sat_count, ref_cnt);
        if (prev_hold) begin
          check("hold_valid", bus.res_valid, 1);
          check("hold_sum", bus.res_sum, prev_sum);
          check("hold_id", bus.res_id, prev_id);
          check("hold_sat", bus.res_sat, prev_sat);
        end
        prev_hold = bus.res_valid && !bus.res_ready;
        prev_sum = bus.res_sum; prev_id = bus.res_id; prev_sat = bus.res_sat;
        inc = 1'b0;
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got result sum %0d id %0d required none (t=%0t)",
                     bus.res_sum, bus.res_id, $time);
          end else begin
            e = exp_q.pop_front();
            check("res_sum", bus.res_sum, e.sum);
            check("res_id", bus.res_id, e.id);
            check("res_sat", bus.res_sat, e.sat);
            inc = e.sat;
            last_sum = bus.res_sum; last_id = bus.res_id; last_sat = bus.res_sat;
            got_ids.push_back(int'(bus.res_id));
            got_cyc.push_back(cyc);
          end
        end
        if (bus.sat_clear) ref_cnt = 0;
        else if (inc && ref_cnt < CNT_MAX) ref_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int a0, b0, base;
    ra[0] = 0; rb[0] = 0; ra[1] = 0; rb[1] = 0;
    bus.req_valid = 2'b11;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready = 1'b1;
    bus.sat_clear = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #12;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_sum", bus.res_sum, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_res_sat", bus.res_sat, 0);
    check("rst_sat_count", bus.sat_count, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic add 3 + -5 from requester 0, result within two edges
    drive(2'b01, 3, -5, 0, 0, 1'b1, 1'b0);
    lat = 0;
    for (int k = 1; k <= 2; k++) begin
      drive(2'b00, 3, -5, 0, 0, 1'b1, 1'b0);
      if (bus.res_valid && lat == 0) lat = k;
    end
    #2;
    check("basic_latency_seen", (lat >= 1 && lat <= 2), 1);
    check("basic_sum", last_sum, 4'hE);
    check("basic_id", last_id, 0);
    check("basic_sat", last_sat, 0);
    drain();
    check("basic_count", bus.sat_count, 0);

    // Positive then negative saturation from requester 1
    drive(2'b10, 0, 0, 7, 1, 1'b1, 1'b0);
    drain();
    check("pos_sum", last_sum, 4'h7);
    check("pos_id", last_id, 1);
    check("pos_sat", last_sat, 1);
    check("pos_count", bus.sat_count, 1);
    drive(2'b10, 0, 0, -8, -1, 1'b1, 1'b0);
    drain();
    check("neg_sum", last_sum, 4'h8);
    check("neg_sat", last_sat, 1);
    check("neg_count", bus.sat_count, 2);

    // Round-robin: both requesters valid, six back-to-back accepts
    got_ids.delete();
    got_cyc.delete();
    for (int k = 0; k < 6; k++) rand_cycle(100, 100, 0, 0);
    drain();
    check("rr_results", (got_ids.size() >= 6), 1);
    if (got_ids.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check("rr_id", got_ids[k], k % 2);
        check("rr_cycle", got_cyc[k] - got_cyc[0], k);
      end
    end

    // Backpressure: requester 0 valid, res_ready low for five cycles
    base = acc_total;
    a0 = rnd(); b0 = rnd();
    for (int k = 0; k < 5; k++) begin
      if (k > 0 && acc[0]) begin a0 = rnd(); b0 = rnd(); end
      drive(2'b01, a0, b0, 0, 0, 1'b0, 1'b0);
      check("bp_ready", bus.req_ready[0], (k < 2) ? 1 : 0);
    end
    check("bp_accepts", acc_total - base, 2);
    drain();

    // Counter sticks at its maximum after five clipped results
    for (int k = 0; k < 5; k++) drive(2'b01, 7, 7, 0, 0, 1'b1, 1'b0);
    drain();
    check("cnt_stick", bus.sat_count, CNT_MAX);

    // Clear coincident with a clipped handshake wins
    drive(2'b01, 7, 7, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 7, 7, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 7, 7, 0, 0, 1'b0, 1'b0);
    drive(2'b00, 7, 7, 0, 0, 1'b1, 1'b1);
    drive(2'b00, 7, 7, 0, 0, 1'b1, 1'b0);
    check("clr_handshake_sat", last_sat, 1);
    check("clr_wins", bus.sat_count, 0);

    // Randomized traffic with drops, backpressure and clears
    for (int k = 0; k < 400; k++) rand_cycle(60, 70, 3, 5);
    drain();

    // Reset with two operations in flight
    drive(2'b01, 1, 1, 0, 0, 1'b0, 1'b0);
    drive(2'b01, 2, 2, 0, 0, 1'b0, 1'b0);
    drive(2'b01, 3, 3, 0, 0, 1'b0, 1'b0);
    check("pre_reset_valid", bus.res_valid, 1);
    mon_en = 1'b0;
    bus.req_valid = 2'b11;
    #2 rst = 1'b0;
    #1;
    check("async_res_valid", bus.res_valid, 0);
    check("async_sat_count", bus.sat_count, 0);
    check("async_req_ready", bus.req_ready, 0);
    exp_q.delete();
    ref_ptr = 0;
    ref_cnt = 0;
    prev_hold = 1'b0;
    acc = 2'b00;
    rv = 2'b00;
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    mon_en = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    check("post_reset_stale", bus.res_valid, 0);
    drive(2'b11, 1, 2, 3, 4, 1'b1, 1'b0);
    check("post_reset_grant", bus.req_ready, 2'b01);
    drive(2'b10, 1, 2, 3, 4, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
